scurve_channel_scheduler: RTL



---
 rtl/scurve_channel_scheduler_pkg.sv | 22 ++
 rtl/scurve_channel_scheduler_mask_load_watchdog.sv | 49 ++++
 rtl/scurve_channel_scheduler.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/scurve_channel_scheduler_pkg.sv
// Shared types and constants for the S-curve channel scheduler.
package scurve_channel_scheduler_pkg;

    localparam int          CHANNEL_NUM = 64;
    localparam int          CH_W        = 6;
    localparam logic [3:0]  HDR_PREFIX  = 4'hC;
    localparam logic [15:0] TAIL_WORD   = 16'hFF43;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HEADER_OUT,
        S_LOAD_MASK,
        S_WAIT_MASK,
        S_START_SWEEP,
        S_WAIT_SWEEP,
        S_WAIT_TX,
        S_NEXT_CH,
        S_TAIL_OUT,
        S_DONE
    } state_t;

endpackage

// File: rtl/scurve_channel_scheduler_mask_load_watchdog.sv
// Issues the slow-control reload pulse and flags a loader that never answers.
module mask_load_watchdog #(
    parameter logic [15:0] TIMEOUT = 16'd50_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic wait_i,
    input  logic done_i,
    input  logic clear_i,
    output logic mask_load_o,
    output logic expired_o,
    output logic timeout_o
);

    logic [15:0] cnt_q, cnt_d;
    logic        load_q;
    logic        timeout_q;

    // Counter is zero in the cycle the pulse is visible, so the flag rises
    // exactly TIMEOUT cycles after MaskLoad.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = '0;
        else if (cnt_q != '1)
            cnt_d = cnt_q + 16'd1;
    end

    assign expired_o   = wait_i && !done_i && (cnt_q == TIMEOUT - 16'd1);
    assign mask_load_o = load_q;
    assign timeout_o   = timeout_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            load_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            load_q <= load_i;
            if (clear_i)
                timeout_q <= 1'b0;
            else if (expired_o)
                timeout_q <= 1'b1;
        end
    end

endmodule

// File: rtl/scurve_channel_scheduler.sv
// Channel sequencer: per channel header, mask load, one DAC0 sweep, data release; then tail.
module scurve_channel_scheduler #(
    parameter int          CHANNEL_NUM       = scurve_channel_scheduler_pkg::CHANNEL_NUM,
    parameter int          CH_W              = scurve_channel_scheduler_pkg::CH_W,
    parameter logic [15:0] MASK_LOAD_TIMEOUT = 16'd50_000
) (
    input  logic                   Clk,
    input  logic                   reset,
    input  logic                   ScanStart,
    input  logic                   ScanAbort,
    input  logic                   SingleChannelMode,
    input  logic [CH_W-1:0]        SingleChannelSel,
    input  logic [CH_W-1:0]        StartChannel,
    input  logic [CH_W-1:0]        EndChannel,
    output logic [CHANNEL_NUM-1:0] ChannelMask,
    output logic                   MaskLoad,
    input  logic                   MaskConfigDone,
    output logic                   SweepStart,
    input  logic                   SweepACQDone,
    input  logic                   HostTransmitDone,
    output logic                   SweepTransmitDone,
    output logic [CH_W-1:0]        CurrentChannel,
    output logic [15:0]            ScanData,
    output logic                   ScanData_en,
    output logic                   ScanBusy,
    output logic                   ScanDone,
    output logic                   ConfigTimeout
);
    import scurve_channel_scheduler_pkg::*;

    localparam logic [CHANNEL_NUM-1:0] ONE_HOT0 = {{(CHANNEL_NUM-1){1'b0}}, 1'b1};

    state_t                 state_q;
    logic [CH_W-1:0]        cur_q, last_q;
    logic [CHANNEL_NUM-1:0] mask_q;
    logic [15:0]            data_q;
    logic                   data_en_q, sweep_q, std_q, busy_q, done_q;
    logic                   start_prev_q;

    logic [CH_W-1:0] first_ch, last_ch;
    logic            start_rise, accept, expired, timeout_flag;

    assign first_ch   = SingleChannelMode ? SingleChannelSel : StartChannel;
    assign last_ch    = SingleChannelMode ? SingleChannelSel : EndChannel;
    assign start_rise = ScanStart && !start_prev_q;
    assign accept     = (state_q == S_IDLE) && start_rise;

    mask_load_watchdog #(
        .TIMEOUT (MASK_LOAD_TIMEOUT)
    ) u_wdog (
        .clk_i       (Clk),
        .rst_i       (reset),
        .load_i      ((state_q == S_LOAD_MASK) && !ScanAbort),
        .wait_i      ((state_q == S_WAIT_MASK) && !ScanAbort),
        .done_i      (MaskConfigDone),
        .clear_i     (accept),
        .mask_load_o (MaskLoad),
        .expired_o   (expired),
        .timeout_o   (timeout_flag)
    );

    // Previous-level register resets high so a ScanStart held through reset
    // must drop and rise again before a scan starts.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cur_q        <= '0;
            last_q       <= '0;
            mask_q       <= '1;
            data_q       <= '0;
            data_en_q    <= 1'b0;
            sweep_q      <= 1'b0;
            std_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            start_prev_q <= 1'b1;
        end else begin
            start_prev_q <= ScanStart;
            data_en_q    <= 1'b0;
            std_q        <= 1'b0;
            done_q       <= 1'b0;
            if (ScanAbort && state_q != S_IDLE) begin
                state_q <= S_IDLE;
                sweep_q <= 1'b0;
                mask_q  <= '1;
                busy_q  <= 1'b0;
                std_q   <= (state_q == S_WAIT_SWEEP) || (state_q == S_WAIT_TX);
            end else begin
                case (state_q)
                    S_IDLE: if (start_rise) begin
                        cur_q   <= first_ch;
                        last_q  <= last_ch;
                        busy_q  <= 1'b1;
                        state_q <= (first_ch > last_ch) ? S_TAIL_OUT : S_HEADER_OUT;
                    end
                    S_HEADER_OUT: begin
                        data_q    <= {HDR_PREFIX, 12'(cur_q)};
                        data_en_q <= 1'b1;
                        state_q   <= S_LOAD_MASK;
                    end
                    S_LOAD_MASK: begin
                        mask_q  <= ~(ONE_HOT0 << cur_q);
                        state_q <= S_WAIT_MASK;
                    end
                    S_WAIT_MASK: begin
                        if (MaskConfigDone) begin
                            state_q <= S_START_SWEEP;
                        end else if (expired) begin
                            mask_q  <= '1;
                            state_q <= S_TAIL_OUT;
                        end
                    end
                    S_START_SWEEP: begin
                        sweep_q <= 1'b1;
                        state_q <= S_WAIT_SWEEP;
                    end
                    S_WAIT_SWEEP: if (SweepACQDone) begin
                        sweep_q <= 1'b0;
                        state_q <= S_WAIT_TX;
                    end
                    S_WAIT_TX: if (HostTransmitDone) begin
                        std_q   <= 1'b1;
                        state_q <= S_NEXT_CH;
                    end
                    S_NEXT_CH: begin
                        if (cur_q == last_q) begin
                            state_q <= S_TAIL_OUT;
                        end else begin
                            cur_q   <= cur_q + 1'b1;
                            state_q <= S_HEADER_OUT;
                        end
                    end
                    S_TAIL_OUT: begin
                        data_q    <= TAIL_WORD;
                        data_en_q <= 1'b1;
                        mask_q    <= '1;
                        state_q   <= S_DONE;
                    end
                    S_DONE: begin
                        done_q  <= !timeout_flag;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign ChannelMask       = mask_q;
    assign SweepStart        = sweep_q;
    assign SweepTransmitDone = std_q;
    assign CurrentChannel    = cur_q;
    assign ScanData          = data_q;
    assign ScanData_en       = data_en_q;
    assign ScanBusy          = busy_q;
    assign ScanDone          = done_q;
    assign ConfigTimeout     = timeout_flag;

endmodule
